playback_engine: RTL and testbench

//  Parametrised successor to the fixed 16-slot playback FSM. Drives a single-bit CAN-side

---
 rtl/playback_engine.sv | 157 +++++++++++++++
 tb/tb_playback_engine.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/playback_engine.sv
// playback_engine
// Plays SLOTS-slot words from an upstream FIFO onto a single-bit drive output,
// one slot per rising edge of play_tick. Supports a repeat count, loop mode,
// pause (enable low), abort and a sticky underflow flag.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   enable          arm/run; low pauses PLAY or re-arms from DONE
//   abort           abandon playback, return to IDLE
//   mode_loop       replay indefinitely, request_num ignored
//   request_num     number of words to play
//   word_valid      FIFO head word available
//   word_data       slot i = word_data[2i+1:2i] = {enable,out}
//   word_ready      pop pulse, asserted in the same cycle the word is taken
//   play_tick       playback clock level; rising edge advances one slot
//   d_out/d_enable  current slot of the shadow word while playing
//   busy            WAIT_WORD or PLAY
//   complete        DONE
//   underflow       sticky; a word was needed but none was available
//   req_count       words fully played since start
module playback_engine #(
    parameter int unsigned SLOTS = 16,
    parameter int unsigned REQ_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 abort,
    input  logic                 mode_loop,
    input  logic [REQ_W-1:0]     request_num,
    input  logic                 word_valid,
    input  logic [2*SLOTS-1:0]   word_data,
    output logic                 word_ready,
    input  logic                 play_tick,
    output logic                 d_out,
    output logic                 d_enable,
    output logic                 busy,
    output logic                 complete,
    output logic                 underflow,
    output logic [REQ_W-1:0]     req_count
);

    localparam int unsigned SLOT_W = $clog2(SLOTS);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_WORD = 2'd1,
        PLAY      = 2'd2,
        DONE      = 2'd3
    } state_t;

    state_t                 state;
    logic [SLOTS-1:0][1:0]  shadowWord;
    logic [SLOT_W-1:0]      slotIdx;
    logic                   tickQ;
    logic                   fromPlay;   // WAIT_WORD was entered from a starved PLAY

    logic                   tick;
    logic                   lastSlot;
    logic                   wordDone;
    logic                   reqMet;
    logic [REQ_W:0]         nextCount;
    logic [1:0]             curSlot;

    // Rising-edge detect of the playback clock
    assign tick      = play_tick & ~tickQ;

    assign lastSlot  = (slotIdx == SLOT_W'(SLOTS - 1));
    assign wordDone  = (state == PLAY) && tick && enable && lastSlot;
    assign nextCount = {1'b0, req_count} + (REQ_W + 1)'(1);
    // Compared one bit wider so an all-ones request cannot wrap
    assign reqMet    = !mode_loop && (nextCount >= {1'b0, request_num});

    // Pop only in the cycle the word is actually latched; never on abort/reset
    assign word_ready = !reset && !abort && word_valid &&
                        ((state == WAIT_WORD) || (wordDone && !reqMet));

    assign curSlot   = shadowWord[slotIdx];
    assign d_enable  = (state == PLAY) && curSlot[1];
    assign d_out     = (state == PLAY) && curSlot[0];
    assign busy      = (state == WAIT_WORD) || (state == PLAY);
    assign complete  = (state == DONE);

    // Playback FSM and datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            slotIdx    <= '0;
            shadowWord <= '0;
            req_count  <= '0;
            underflow  <= 1'b0;
            tickQ      <= 1'b0;
            fromPlay   <= 1'b0;
        end else begin
            tickQ <= play_tick;
            if (abort) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            req_count <= '0;
                            underflow <= 1'b0;
                            fromPlay  <= 1'b0;
                            if (!mode_loop && (request_num == '0)) begin
                                state <= DONE;
                            end else begin
                                state <= WAIT_WORD;
                            end
                        end
                    end
                    WAIT_WORD: begin
                        if (tick && fromPlay) begin
                            underflow <= 1'b1;
                        end
                        if (word_valid) begin
                            shadowWord <= word_data;
                            slotIdx    <= '0;
                            fromPlay   <= 1'b0;
                            state      <= PLAY;
                        end
                    end
                    PLAY: begin
                        if (tick && enable) begin
                            if (!lastSlot) begin
                                slotIdx <= slotIdx + SLOT_W'(1);
                            end else begin
                                if (mode_loop) begin
                                    req_count <= '0;
                                end else if (req_count != {REQ_W{1'b1}}) begin
                                    req_count <= req_count + REQ_W'(1);
                                end
                                if (reqMet) begin
                                    state <= DONE;
                                end else if (word_valid) begin
                                    shadowWord <= word_data;
                                    slotIdx    <= '0;
                                end else begin
                                    state     <= WAIT_WORD;
                                    underflow <= 1'b1;
                                    fromPlay  <= 1'b1;
                                end
                            end
                        end
                    end
                    DONE: begin
                        if (!enable) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_playback_engine.sv
// tb_playback_engine
// Directed bench for playback_engine (SLOTS=16, REQ_W=16). Stimulus pushes the
// expected slot value of every tick into a queue; a negedge monitor pops and
// compares it against {d_enable,d_out} when it sees the tick. A small FIFO model
// feeds words and pops on the valid/ready handshake.
module tb_playback_engine;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        abort;
    logic        mode_loop;
    logic [15:0] request_num;
    logic        word_valid;
    logic [31:0] word_data;
    logic        word_ready;
    logic        play_tick;
    logic        d_out;
    logic        d_enable;
    logic        busy;
    logic        complete;
    logic        underflow;
    logic [15:0] req_count;

    logic [31:0] fifo[$];
    logic [1:0]  expQ[$];
    int          total;
    int          bad;
    int          readyCount;
    bit          tickPrev;
    bit          readyPrev;
    bit          loopPhase;
    bit          completeSeen;

    playback_engine #(.SLOTS(16), .REQ_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .abort      (abort),
        .mode_loop  (mode_loop),
        .request_num(request_num),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .play_tick  (play_tick),
        .d_out      (d_out),
        .d_enable   (d_enable),
        .busy       (busy),
        .complete   (complete),
        .underflow  (underflow),
        .req_count  (req_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] slotOf(input logic [31:0] w, input int i);
        logic [31:0] tmp;
        tmp = w;
        return tmp[2*i +: 2];
    endfunction

    function automatic logic [31:0] loopWord(input int k);
        return 32'(k + 1) * 32'h9E37_79B9;
    endfunction

    // FIFO model: pop on handshake seen at negedge, refresh head just after posedge
    initial begin
        bit doPop;
        word_valid = 1'b0;
        word_data  = '0;
        forever begin
            @(negedge clk);
            doPop = word_valid && word_ready;
            @(posedge clk);
            #2;
            if (doPop && fifo.size() > 0) void'(fifo.pop_front());
            word_valid = (fifo.size() > 0);
            word_data  = (fifo.size() > 0) ? fifo[0] : 32'h0;
        end
    end

    // Monitor: slot scoreboard, word_ready spacing, complete during loop mode
    always @(negedge clk) begin
        if (play_tick && !tickPrev) begin
            if (expQ.size() == 0) begin
                check("slot_unexpected", {30'h0, d_enable, d_out}, 32'hFFFF_FFFF);
            end else begin
                check("slot", {30'h0, d_enable, d_out}, {30'h0, expQ.pop_front()});
            end
        end
        tickPrev = play_tick;
        if (word_ready) begin
            readyCount++;
            check("ready_back_to_back", {31'h0, readyPrev}, 32'h0);
        end
        readyPrev = word_ready;
        if (loopPhase && complete) completeSeen = 1'b1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic doTick(input logic [1:0] e);
        expQ.push_back(e);
        play_tick = 1'b1;
        cyc(1);
        play_tick = 1'b0;
        cyc(1);
    endtask

    task automatic playWord(input logic [31:0] w);
        for (int i = 0; i < 16; i++) doTick(slotOf(w, i));
    endtask

    localparam logic [31:0] W1 = 32'hA5C3_96E1;
    localparam logic [31:0] W2 = 32'h3C5A_F00F;
    localparam logic [31:0] W3 = 32'h5A5A_0FF0;
    localparam logic [31:0] W4 = 32'hC3A5_1E87;
    localparam logic [31:0] W5 = 32'h1234_ABCD;
    localparam logic [31:0] W6 = 32'h6B1D_E270;
    localparam logic [31:0] W7 = 32'hF0C3_5A96;
    localparam logic [31:0] W8 = 32'h8E7D_4B21;

    initial begin
        int base;
        total = 0; bad = 0; readyCount = 0;
        tickPrev = 1'b0; readyPrev = 1'b0; loopPhase = 1'b0; completeSeen = 1'b0;
        reset = 1'b1; enable = 1'b0; abort = 1'b0; mode_loop = 1'b0;
        request_num = '0; play_tick = 1'b0;

        // Reset state
        cyc(3);
        reset = 1'b0;
        check("rst_dout", {31'h0, d_out}, 32'h0);
        check("rst_denable", {31'h0, d_enable}, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_complete", {31'h0, complete}, 32'h0);
        check("rst_underflow", {31'h0, underflow}, 32'h0);
        check("rst_req_count", {16'h0, req_count}, 32'h0);
        cyc(2);

        // Two words back to back, request_num=2
        base = readyCount;
        request_num = 16'd2;
        fifo.push_back(W1);
        fifo.push_back(W2);
        enable = 1'b1;
        cyc(3);
        check("t1_busy", {31'h0, busy}, 32'h1);
        check("t1_ready_first", 32'(readyCount - base), 32'd1);
        playWord(W1);
        check("t1_req_count_mid", {16'h0, req_count}, 32'd1);
        playWord(W2);
        check("t1_complete", {31'h0, complete}, 32'h1);
        check("t1_denable_done", {31'h0, d_enable}, 32'h0);
        check("t1_req_count", {16'h0, req_count}, 32'd2);
        check("t1_ready_total", 32'(readyCount - base), 32'd2);
        check("t1_underflow", {31'h0, underflow}, 32'h0);
        enable = 1'b0;
        cyc(2);
        check("t1_rearm", {31'h0, complete}, 32'h0);

        // request_num=0 finishes without taking a word
        base = readyCount;
        request_num = 16'd0;
        fifo.push_back(W3);
        cyc(1);
        enable = 1'b1;
        cyc(1);
        check("t2_complete", {31'h0, complete}, 32'h1);
        check("t2_denable", {31'h0, d_enable}, 32'h0);
        cyc(2);
        check("t2_no_ready", 32'(readyCount - base), 32'd0);
        enable = 1'b0;
        cyc(2);

        // Underflow at word boundary, then resume at slot 0
        base = readyCount;
        request_num = 16'd2;
        enable = 1'b1;
        cyc(3);
        playWord(W3);
        check("t3_busy", {31'h0, busy}, 32'h1);
        check("t3_denable", {31'h0, d_enable}, 32'h0);
        check("t3_underflow", {31'h0, underflow}, 32'h1);
        check("t3_req_count", {16'h0, req_count}, 32'd1);
        doTick(2'b00);
        doTick(2'b00);
        fifo.push_back(W4);
        cyc(3);
        check("t3_ready", 32'(readyCount - base), 32'd2);
        playWord(W4);
        check("t3_complete", {31'h0, complete}, 32'h1);
        check("t3_underflow_sticky", {31'h0, underflow}, 32'h1);
        enable = 1'b0;
        cyc(2);

        // Pause at slot 7 for five ticks
        request_num = 16'd1;
        fifo.push_back(W5);
        enable = 1'b1;
        cyc(3);
        for (int i = 0; i < 7; i++) doTick(slotOf(W5, i));
        enable = 1'b0;
        for (int i = 0; i < 5; i++) doTick(slotOf(W5, 7));
        check("t4_held", {30'h0, d_enable, d_out}, {30'h0, slotOf(W5, 7)});
        check("t4_busy", {31'h0, busy}, 32'h1);
        enable = 1'b1;
        cyc(1);
        for (int i = 7; i < 16; i++) doTick(slotOf(W5, i));
        check("t4_complete", {31'h0, complete}, 32'h1);
        enable = 1'b0;
        cyc(2);

        // Abort at slot 3 of the second word, then restart
        base = readyCount;
        request_num = 16'd3;
        fifo.push_back(W6);
        fifo.push_back(W7);
        enable = 1'b1;
        cyc(3);
        playWord(W6);
        for (int i = 0; i < 3; i++) doTick(slotOf(W7, i));
        abort = 1'b1;
        cyc(1);
        check("t5_busy", {31'h0, busy}, 32'h0);
        check("t5_denable", {31'h0, d_enable}, 32'h0);
        check("t5_complete", {31'h0, complete}, 32'h0);
        abort = 1'b0;
        enable = 1'b0;
        cyc(2);
        check("t5_ready", 32'(readyCount - base), 32'd2);
        check("t5_req_count_held", {16'h0, req_count}, 32'd1);
        request_num = 16'd1;
        fifo.push_back(W8);
        enable = 1'b1;
        cyc(1);
        check("t5_req_count_clear", {16'h0, req_count}, 32'd0);
        cyc(2);
        playWord(W8);
        check("t5_complete_restart", {31'h0, complete}, 32'h1);
        check("t5_req_count_end", {16'h0, req_count}, 32'd1);
        check("t5_ready_restart", 32'(readyCount - base), 32'd3);
        enable = 1'b0;
        cyc(2);

        // Loop mode, 100 words with the FIFO always stocked
        base = readyCount;
        mode_loop = 1'b1;
        request_num = 16'd0;
        for (int k = 0; k < 101; k++) fifo.push_back(loopWord(k));
        cyc(1);
        loopPhase = 1'b1;
        enable = 1'b1;
        cyc(3);
        for (int k = 0; k < 100; k++) begin
            playWord(loopWord(k));
            if (k % 25 == 24) begin
                check("t6_req_count", {16'h0, req_count}, 32'd0);
                check("t6_busy", {31'h0, busy}, 32'h1);
            end
        end
        loopPhase = 1'b0;
        check("t6_complete_never", {31'h0, completeSeen}, 32'h0);
        check("t6_underflow", {31'h0, underflow}, 32'h0);
        check("t6_ready", 32'(readyCount - base), 32'd101);
        abort = 1'b1;
        enable = 1'b0;
        mode_loop = 1'b0;
        fifo.delete();
        cyc(1);
        abort = 1'b0;
        cyc(2);
        check("t6_idle", {31'h0, busy}, 32'h0);

        check("sb_empty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
